// File: rtl/reg_bank.sv
// reg_bank: parameterised register bank with two registered read ports,
// a four-source write port with same-cycle read bypass, and a per-register
// busy scoreboard that raises a combinational stall on operand hazards.
module reg_bank #(
    parameter int unsigned     DW    = 8,
    parameter int unsigned     NREG  = 8,
    parameter logic [DW-1:0]   ENTRY = '0,
    localparam int unsigned    AW    = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] rd_addr_a,
    input  logic [AW-1:0] rd_addr_b,
    input  logic          imm_sel,
    input  logic [DW-1:0] immediate,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [1:0]    wr_src,
    input  logic [AW-1:0] copy_addr,
    input  logic [DW-1:0] data_in,
    input  logic          busy_set,
    input  logic [AW-1:0] busy_set_addr,
    input  logic          busy_clr,
    input  logic [AW-1:0] busy_clr_addr,
    output logic [DW-1:0] data_out_a,
    output logic [DW-1:0] data_out_b,
    output logic          stall
);

    typedef enum logic [1:0] {
        SRC_DATA  = 2'b00,
        SRC_COPY  = 2'b01,
        SRC_IMM   = 2'b10,
        SRC_ENTRY = 2'b11
    } wr_src_e;

    logic [DW-1:0]   regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;

    logic [DW-1:0]   wv;
    logic            wr_hit;
    logic [DW-1:0]   rd_val_a;
    logic [DW-1:0]   rd_val_b;
    logic            busy_a;
    logic            busy_b;
    logic            early_clr_a;
    logic            early_clr_b;

    // An index names a real register only below NREG; the address space may
    // be larger when NREG is not a power of two.
    function automatic logic in_range(input logic [AW-1:0] addr);
        return {1'b0, addr} < (AW+1)'(NREG);
    endfunction

    // Out-of-range reads see zero instead of whatever the index decodes to.
    function automatic logic [DW-1:0] read_reg(input logic [AW-1:0] addr);
        return in_range(addr) ? regs[addr] : '0;
    endfunction

    // Select the write value; a copy uses the source register's pre-edge value.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        wv = data_in;
        case (wr_src_e'(wr_src))
            SRC_DATA:  wv = data_in;
            SRC_COPY:  wv = read_reg(copy_addr);
            SRC_IMM:   wv = immediate;
            SRC_ENTRY: wv = ENTRY;
            default:   wv = data_in;
        endcase
    end

    assign wr_hit = wr_en && in_range(wr_addr);

    // Read muxes: a same-cycle write to the addressed register is forwarded.
    always_comb begin
        rd_val_a = read_reg(rd_addr_a);
        rd_val_b = read_reg(rd_addr_b);
        if (wr_hit && (wr_addr == rd_addr_a)) begin
            rd_val_a = wv;
        end
        if (wr_hit && (wr_addr == rd_addr_b)) begin
            rd_val_b = wv;
        end
    end

    // Scoreboard update: clear first, then set, so a simultaneous set wins.
    always_comb begin
        busy_next = busy;
        if (busy_clr && in_range(busy_clr_addr)) begin
            busy_next[busy_clr_addr] = 1'b0;
        end
        if (busy_set && in_range(busy_set_addr)) begin
            busy_next[busy_set_addr] = 1'b1;
        end
    end

    // Hazard detection: a load returning this cycle no longer blocks its reader.
    always_comb begin
        busy_a      = in_range(rd_addr_a) && busy[rd_addr_a];
        busy_b      = in_range(rd_addr_b) && busy[rd_addr_b];
        early_clr_a = busy_clr && (busy_clr_addr == rd_addr_a);
        early_clr_b = busy_clr && (busy_clr_addr == rd_addr_b);
        stall       = (busy_a && !early_clr_a) ||
                      (!imm_sel && busy_b && !early_clr_b);
    end

    // Register array storage; reset clears every entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the whole array is reset because software expects every
            // register to read zero after reset; this rules out a RAM macro.
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_hit) begin
            // NOTE: sequential state uses non-blocking assignment so that
            // reads of regs elsewhere in this edge see the pre-edge value.
            regs[wr_addr] <= wv;
        end
    end

    // Busy scoreboard state; reset drops any outstanding loads.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Registered read ports; port B returns the immediate when selected.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_a <= '0;
            data_out_b <= '0;
        end else begin
            data_out_a <= rd_val_a;
            data_out_b <= imm_sel ? immediate : rd_val_b;
        end
    end

endmodule
